fringe_generator: RTL and testbench
===================================

// Module: fringe_generator
// PURPOSE
//  Synthesizes the two-channel fringe stream that the position tracking path consumes. Input is a
//  signed target position; output is quadrature channel pair {B,A}, stepping fringe by fringe until
//  internal position is within one step of target. Used as stimulus source and closed-loop self-test
//  in front of the tracker: tracker count must equal gen_position.
// PARAMETERS
//  AXIS_TDATA_WIDTH  32  stream width; each channel is AXIS_TDATA_WIDTH/2 bits signed, position is full width signed
// PORTS
//  aclk            in   1     clock
//  aresetn         in   1     synchronous, active-low reset
//  FC_low_level    in   W/2   signed channel level for logic-low
//  FC_high_level   in   W/2   signed channel level for logic-high
//  FC_log_scale    in   5     position step per fringe = 1<<FC_log_scale
//  FC_hold_cycles  in   16    accepted output beats per quadrature phase (0 treated as 1)
//  S_AXIS_tvalid   in   1     target position valid
//  S_AXIS_tdata    in   W     signed target position
//  S_AXIS_tready   out  1     constant 1 (target always accepted)
//  M_AXIS_tready   in   1     downstream accepts beat
//  M_AXIS_tvalid   out  1     output beat valid
//  M_AXIS_tdata    out  W     {B[W-1:W/2], A[W/2-1:0]}
//  gen_position    out  W     signed internal position
//  busy            out  1     1 while a fringe is in progress (phase != P0)
// BEHAVIOUR
//  - Reset: target=0, gen_position=0, phase=P0, beat counter=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, busy=0.
//  - First cycle after reset release: tvalid=1 permanently; tdata always = levels of current phase register
//    (registered in lockstep with phase, no extra latency). H=FC_high_level, L=FC_low_level.
//  - Phases (A,B): P0=(H,H) P1=(L,H) P2=(L,L) P3=(H,L). Forward: P0>P1>P2>P3>P0. Backward: P0>P3>P2>P1>P0.
//  - Target register loads S_AXIS_tdata on every cycle with S_AXIS_tvalid=1; new value only used at next P0 decision.
//  - Beat counter advances only on tvalid&tready; phase transition when counter reaches max(hold,1)-1 on an
//    accepted beat, counter then clears. tready=0 freezes counter, phase, tdata.
//  - Decision only at end of P0 hold: d = target - gen_position computed in W+1 bits (no overflow).
//    d >= step -> forward fringe; -d >= step -> backward fringe; else stay in P0 (restart hold count).
//  - A fringe, once started, always completes all four phases; direction latched at start.
//  - Position update on the A-falling transition only: forward P0>P1 (B=H) adds step; backward P3>P2 (B=L)
//    subtracts step. Arithmetic two's complement, wraps modulo 2^W.
//  - FC_* inputs sampled live; changing levels mid-phase changes tdata next cycle; changing FC_log_scale
//    mid-fringe uses value present at the A-falling transition.
//  - Reset mid-fringe returns immediately to reset state; no partial position update.
//  - busy = (phase != P0).
// TESTING
//  1 Reset held 3 cycles -> tvalid=0, tdata=0; release -> tvalid=1, tdata={H,H}, gen_position=0, busy=0.
//  2 H=1000 L=-1000 log_scale=2 hold=3 tready=1, target=8 -> 2 forward fringes, each phase 3 beats, A falls
//    with B=1000, gen_position 0>4>8, busy low after 24 beats, then idles in P0.
//  3 From 0, target=-4 -> phases P3,P2,P1,P0; A falls with B=-1000; gen_position=-4 on P3>P2.
//  4 target=6, step 4 -> one fringe only, gen_position=4, remains in P0 (residual 2 < step).
//  5 Mid-phase tready low 10 cycles -> tdata, phase, counter frozen; phase resumes with remaining beats.
//  6 target 8 then 0 written during first fringe -> first fringe completes (pos 4), then one backward fringe
//    to 0; loopback into tracker with thresholds -500/+500, scale 2 -> tracker count equals gen_position.

Source files
------------

// File: rtl/fringe_generator.sv
// Quadrature fringe stream generator.
// Steps a four-phase {B,A} pattern until the internal position is within one
// step of the requested target. Each phase lasts a programmable number of
// accepted output beats, and the position moves on the falling edge of A.
module fringe_generator #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_low_level,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_high_level,
  input  logic [4:0]                         FC_log_scale,
  input  logic [15:0]                        FC_hold_cycles,
  input  logic                               S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]        S_AXIS_tdata,
  output logic                               S_AXIS_tready,
  input  logic                               M_AXIS_tready,
  output logic                               M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
  output logic [AXIS_TDATA_WIDTH-1:0]        gen_position,
  output logic                               busy
);
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int HW = AXIS_TDATA_WIDTH / 2;

  // Phase (A,B): P0=(H,H) P1=(L,H) P2=(L,L) P3=(H,L)
  typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} phase_t;

  phase_t          phase_q, phase_d;
  logic            fwd_q, fwd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [W-1:0]    pos_q, pos_d;
  logic [W-1:0]    target_q, target_d;
  logic [W-1:0]    tdata_q, tdata_d;
  logic            tvalid_q;

  logic [15:0]     hold_eff;
  logic            accept;
  logic            last_beat;
  logic signed [W:0] step_ext;
  logic signed [W:0] diff;
  logic signed [W:0] neg_diff;
  logic [HW-1:0]   lvl_a;
  logic [HW-1:0]   lvl_b;

  assign S_AXIS_tready = 1'b1;
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tdata  = tdata_q;
  assign gen_position  = pos_q;
  assign busy          = (phase_q != P0);

  // Next-state: beat counting, fringe decision, position update and output levels
  always_comb begin
    phase_d   = phase_q;
    fwd_d     = fwd_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    target_d  = S_AXIS_tvalid ? S_AXIS_tdata : target_q;
    tdata_d   = tdata_q;
    hold_eff  = (FC_hold_cycles == 16'd0) ? 16'd1 : FC_hold_cycles;
    accept    = tvalid_q & M_AXIS_tready;
    last_beat = (cnt_q == hold_eff - 16'd1);
    // Signed distance in one extra bit so the subtraction cannot overflow
    step_ext  = $signed({{W{1'b0}}, 1'b1} << FC_log_scale);
    diff      = $signed({target_q[W-1], target_q}) - $signed({pos_q[W-1], pos_q});
    neg_diff  = -diff;

    if (accept) begin
      if (last_beat) begin
        cnt_d = 16'd0;
        unique case (phase_q)
          P0: begin
            if (diff >= step_ext) begin
              // Forward fringe: A falls now with B high, position advances
              phase_d = P1;
              fwd_d   = 1'b1;
              pos_d   = pos_q + step_ext[W-1:0];
            end else if (neg_diff >= step_ext) begin
              phase_d = P3;
              fwd_d   = 1'b0;
            end
          end
          P1: phase_d = fwd_q ? P2 : P0;
          P2: phase_d = fwd_q ? P3 : P1;
          P3: begin
            if (fwd_q) begin
              phase_d = P0;
            end else begin
              // Backward fringe: A falls here with B low, position retreats
              phase_d = P2;
              pos_d   = pos_q - step_ext[W-1:0];
            end
          end
          default: phase_d = P0;
        endcase
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    lvl_a = (phase_d == P0 || phase_d == P3) ? FC_high_level : FC_low_level;
    lvl_b = (phase_d == P0 || phase_d == P1) ? FC_high_level : FC_low_level;
    // Output data is held while a presented beat is stalled
    if (M_AXIS_tready || !tvalid_q) begin
      tdata_d = {lvl_b, lvl_a};
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q  <= P0;
      fwd_q    <= 1'b1;
      cnt_q    <= 16'd0;
      pos_q    <= '0;
      target_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      fwd_q    <= fwd_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      tdata_q  <= tdata_d;
      tvalid_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fringe_generator.sv
// Testbench for fringe_generator: a beat-sequence model expands each fringe
// decision into the expected run of phases and positions, plus a quadrature
// tracker fed from the output stream.
module tb_fringe_generator;
  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic signed [15:0] hl = 16'sd1000;
  logic signed [15:0] ll = -16'sd1000;
  logic [4:0]         scale = 5'd2;
  logic [15:0]        hold = 16'd3;
  logic               s_tvalid = 1'b0;
  logic [31:0]        s_tdata = '0;
  logic               s_tready;
  logic               m_tready = 1'b1;
  logic               m_tvalid;
  logic [31:0]        m_tdata;
  logic [31:0]        gen_pos;
  logic               busy;

  int errors = 0;
  int checks = 0;

  fringe_generator #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .FC_low_level(ll), .FC_high_level(hl),
    .FC_log_scale(scale), .FC_hold_cycles(hold),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready),
    .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tdata(m_tdata),
    .gen_position(gen_pos), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lv(input logic [1:0] ph);
    logic [15:0] a, b;
    a = (ph == 2'd0 || ph == 2'd3) ? hl : ll;
    b = (ph == 2'd0 || ph == 2'd1) ? hl : ll;
    return {b, a};
  endfunction

  // Expected beats: phase shown, position shown, and whether this P0 beat ends a hold
  typedef struct {
    logic [1:0]  ph;
    logic [31:0] pos;
    bit          dec;
  } beat_t;
  beat_t       expq[$];
  logic [31:0] m_pos;
  logic [31:0] m_target;
  bit          out_live = 0;
  bit          seen_rst = 0;
  int          busy_beats;
  bit          trk_a;
  logic [31:0] trk;

  function automatic int heff();
    return (hold == 16'd0) ? 1 : int'(hold);
  endfunction

  task automatic push_block(input logic [1:0] ph, input logic [31:0] pos, input bit dec);
    for (int i = 0; i < heff(); i++) expq.push_back('{ph, pos, dec && (i == heff() - 1)});
  endtask

  task automatic model_init();
    expq.delete();
    m_pos = '0;
    m_target = '0;
    busy_beats = 0;
    trk_a = 1'b1;
    trk = '0;
    push_block(2'd0, 32'd0, 1'b1);
  endtask

  // Decide the next fringe from target and position in wide arithmetic
  task automatic model_decide();
    longint d, st;
    d  = longint'($signed(m_target)) - longint'($signed(m_pos));
    st = longint'(1) << scale;
    if (d >= st) begin
      m_pos = m_pos + 32'(st);
      push_block(2'd1, m_pos, 1'b0);
      push_block(2'd2, m_pos, 1'b0);
      push_block(2'd3, m_pos, 1'b0);
    end else if (-d >= st) begin
      push_block(2'd3, m_pos, 1'b0);
      m_pos = m_pos - 32'(st);
      push_block(2'd2, m_pos, 1'b0);
      push_block(2'd1, m_pos, 1'b0);
    end
    push_block(2'd0, m_pos, 1'b1);
  endtask

  // Quadrature tracker: hysteresis thresholds +-500, counts on A falling
  task automatic tracker(input logic [31:0] td);
    logic signed [15:0] a, b;
    bit na;
    a = td[15:0];
    b = td[31:16];
    na = (a > 16'sd500) ? 1'b1 : (a < -16'sd500) ? 1'b0 : trk_a;
    if (trk_a && !na) trk = (b > 16'sd500) ? trk + (32'd1 << scale) : trk - (32'd1 << scale);
    trk_a = na;
  endtask

  initial forever begin
    @(posedge aclk);
    out_live = aresetn;
    if (!aresetn) seen_rst = 1;
  end

  // Compare process: every negedge, against the model head beat
  initial begin
    model_init();
    forever begin
      @(negedge aclk);
      if (!out_live) begin
        if (seen_rst) begin
          chk("rst_tvalid", 64'(m_tvalid), 64'd0);
          chk("rst_tdata", 64'(m_tdata), 64'd0);
          chk("rst_pos", 64'(gen_pos), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
        end
      end else if (expq.size() == 0) begin
        chk("model_queue_empty", 64'd1, 64'd0);
        model_init();
      end else begin
        chk("tvalid", 64'(m_tvalid), 64'd1);
        chk("tdata", 64'(m_tdata), 64'(lv(expq[0].ph)));
        chk("gen_position", 64'(gen_pos), 64'(expq[0].pos));
        chk("busy", 64'(busy), 64'(expq[0].ph != 2'd0));
        if (m_tready) begin
          beat_t b;
          b = expq.pop_front();
          if (b.ph != 2'd0) busy_beats++;
          tracker(m_tdata);
          if (b.dec) model_decide();
        end
      end
      if (!aresetn) model_init();
      else if (s_tvalid) m_target = s_tdata;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] h, input logic [4:0] sc);
    aresetn = 1'b0;
    hold = h;
    scale = sc;
    cyc(3);
    aresetn = 1'b1;
    cyc(1);
  endtask

  task automatic write_target(input logic [31:0] v);
    s_tdata = v;
    s_tvalid = 1'b1;
    cyc(1);
    s_tvalid = 1'b0;
  endtask

  initial begin
    // 1: reset, then first beat
    cyc(3);
    chk("t1_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("t1_rst_tdata", 64'(m_tdata), 64'd0);
    aresetn = 1'b1;
    cyc(1);
    chk("t1_tvalid", 64'(m_tvalid), 64'd1);
    chk("t1_tdata", 64'(m_tdata), 64'h03E8_03E8);
    chk("t1_pos", 64'(gen_pos), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    $display("t1 reset/release done pos=%0d", $signed(gen_pos));

    // 2: two forward fringes to 8
    write_target(32'd8);
    cyc(40);
    chk("t2_pos", 64'(gen_pos), 64'd8);
    chk("t2_busy_beats", 64'(busy_beats), 64'd18);
    chk("t2_trk", 64'(trk), 64'(gen_pos));
    $display("t2 target=8 pos=%0d busy_beats=%0d", $signed(gen_pos), busy_beats);

    // 3: one backward fringe to -4
    do_reset(16'd3, 5'd2);
    write_target(-32'sd4);
    cyc(25);
    chk("t3_pos", 64'(gen_pos), 64'hFFFF_FFFC);
    chk("t3_trk", 64'(trk), 64'hFFFF_FFFC);
    $display("t3 target=-4 pos=%0d", $signed(gen_pos));

    // 4: residual smaller than a step
    do_reset(16'd3, 5'd2);
    write_target(32'd6);
    cyc(40);
    chk("t4_pos", 64'(gen_pos), 64'd4);
    chk("t4_busy", 64'(busy), 64'd0);
    $display("t4 target=6 pos=%0d", $signed(gen_pos));

    // 5: stall mid-phase for 10 cycles
    do_reset(16'd3, 5'd2);
    write_target(32'd8);
    cyc(5);
    m_tready = 1'b0;
    cyc(10);
    m_tready = 1'b1;
    cyc(45);
    chk("t5_pos", 64'(gen_pos), 64'd8);
    $display("t5 stall pos=%0d", $signed(gen_pos));

    // 6: target changed mid-fringe, tracker loopback
    do_reset(16'd3, 5'd2);
    write_target(32'd8);
    cyc(4);
    write_target(32'd0);
    cyc(50);
    chk("t6_pos", 64'(gen_pos), 64'd0);
    chk("t6_trk", 64'(trk), 64'(gen_pos));
    $display("t6 retarget pos=%0d trk=%0d", $signed(gen_pos), $signed(trk));

    // 7: hold of zero behaves as one beat per phase
    do_reset(16'd0, 5'd2);
    write_target(32'd4);
    cyc(12);
    chk("t7_pos", 64'(gen_pos), 64'd4);
    $display("t7 hold=0 pos=%0d", $signed(gen_pos));

    // 8: extreme distances with a 2^31 step
    do_reset(16'd2, 5'd31);
    write_target(32'h7FFF_FFFF);
    cyc(16);
    chk("t8_pos_stay", 64'(gen_pos), 64'd0);
    write_target(32'h8000_0000);
    cyc(16);
    chk("t8_pos_back", 64'(gen_pos), 64'h8000_0000);
    chk("t8_busy", 64'(busy), 64'd0);
    $display("t8 wide step pos=%0h", gen_pos);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
